// File: rtl/keycode_arbiter.sv
// -----------------------------------------------------------------------------
// keycode_arbiter
//
// Purpose:
//   Producer side of the 8-bit keycode interface that feeds the ball motion
//   block. Once per frame it may receive a 6-slot HID keyboard report. From
//   that report it works out which of the four direction keys (W/A/S/D) are
//   held, and keeps them in press order. The registered keycode output is the
//   most recently pressed direction key that is still held, or 00 when none.
//   If reports stop arriving for TIMEOUT_FRAMES frames, everything is
//   force-released and the block sits in a STALE state until the next report.
//
// Ports:
//   frame_clk     in   1       frame clock; all state updates on posedge
//   Reset         in   1       synchronous, active-high reset
//   report_valid  in   1       report_keys carries a fresh report this cycle
//   report_keys   in   48      6 HID keycodes, slot i = [8i+7:8i], 00 = empty
//   keycode       out  8       selected direction key, 00 = none
//   key_event     out  1       one-cycle pulse when keycode takes a new value
//   held_frames   out  HOLD_W  frames the current nonzero keycode has been
//                              stable, saturating
//   stale         out  1       high while reports have timed out
// -----------------------------------------------------------------------------
module keycode_arbiter #(
  parameter logic [7:0]  KEY_UP         = 8'h1A,
  parameter logic [7:0]  KEY_LEFT       = 8'h04,
  parameter logic [7:0]  KEY_DOWN       = 8'h16,
  parameter logic [7:0]  KEY_RIGHT      = 8'h07,
  parameter int unsigned TIMEOUT_FRAMES = 30,
  parameter int unsigned HOLD_W         = 8
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic              report_valid,
  input  logic [47:0]       report_keys,
  output logic [7:0]        keycode,
  output logic              key_event,
  output logic [HOLD_W-1:0] held_frames,
  output logic              stale
);

  // Counter wide enough to hold TIMEOUT_FRAMES itself, which is where it
  // parks while STALE.
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_FRAMES);

  // Internal 2-bit key identifiers; the held mask uses the same bit order.
  localparam logic [1:0] IDX_UP    = 2'd0;
  localparam logic [1:0] IDX_LEFT  = 2'd1;
  localparam logic [1:0] IDX_DOWN  = 2'd2;
  localparam logic [1:0] IDX_RIGHT = 2'd3;

  typedef enum logic [0:0] {
    LIVE  = 1'b0,
    STALE = 1'b1
  } state_t;

  // Press-order list: entry 0 is the oldest, entry count_q-1 the newest.
  state_t                  state_q,   state_d;
  logic [3:0][1:0]         list_q,    list_d;
  logic [2:0]              count_q,   count_d;
  logic [3:0]              prev_q,    prev_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [7:0]              keycode_q, keycode_d;
  logic                    event_q,   event_d;
  logic [HOLD_W-1:0]       held_q,    held_d;

  // Combinational helpers
  logic [5:0][3:0]         slotHit;
  logic [3:0]              newMask;
  logic [2:0]              baseCount;
  logic [3:0]              basePrev;
  logic [3:0]              pressed;
  logic [3:0]              appended;
  logic [3:0][1:0]         mergeList;
  logic [2:0]              mergeCount;
  logic [1:0]              newestIdx;

  function automatic logic [7:0] idxToCode(input logic [1:0] idx);
    logic [7:0] code;
    case (idx)
      IDX_UP:    code = KEY_UP;
      IDX_LEFT:  code = KEY_LEFT;
      IDX_DOWN:  code = KEY_DOWN;
      default:   code = KEY_RIGHT;
    endcase
    return code;
  endfunction

  // Decode every slot into a one-hot direction hit. OR-ing the hits gives the
  // held mask, so a key repeated in several slots still counts once and any
  // non-direction code simply contributes nothing.
  always_comb begin
    newMask = '0;
    for (int s = 0; s < 6; s++) begin
      slotHit[s]            = '0;
      slotHit[s][IDX_UP]    = (report_keys[8*s +: 8] == KEY_UP);
      slotHit[s][IDX_LEFT]  = (report_keys[8*s +: 8] == KEY_LEFT);
      slotHit[s][IDX_DOWN]  = (report_keys[8*s +: 8] == KEY_DOWN);
      slotHit[s][IDX_RIGHT] = (report_keys[8*s +: 8] == KEY_RIGHT);
      newMask               = newMask | slotHit[s];
    end
  end

  // Build the candidate list for an incoming report. Coming out of STALE the
  // old list and mask are treated as empty, so every held key counts as new.
  // Survivors keep their relative order; new presses are appended in slot
  // order, so the highest-slot new key ends up newest. A key appearing in
  // several slots is placed by its first slot only.
  always_comb begin
    baseCount  = (state_q == STALE) ? 3'd0 : count_q;
    basePrev   = (state_q == STALE) ? 4'd0 : prev_q;
    pressed    = newMask & ~basePrev;
    mergeList  = '0;
    mergeCount = '0;
    appended   = '0;

    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < baseCount) && newMask[list_q[i]]) begin
        mergeList[mergeCount[1:0]] = list_q[i];
        mergeCount                 = mergeCount + 3'd1;
      end
    end

    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (slotHit[s][k] && pressed[k] && !appended[k]) begin
          mergeList[mergeCount[1:0]] = 2'(k);
          mergeCount                 = mergeCount + 3'd1;
          appended[k]                = 1'b1;
        end
      end
    end
  end

  // State / list / timeout next-state. A report always wins over the timeout
  // threshold in the same cycle. Without a report the list holds and the
  // idle counter runs; the edge on which it would reach TIMEOUT_FRAMES moves
  // us into STALE with everything released.
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    count_d = count_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;

    if (report_valid) begin
      state_d = LIVE;
      list_d  = mergeList;
      count_d = mergeCount;
      prev_d  = newMask;
      cnt_d   = '0;
    end else if (state_q == LIVE) begin
      if (cnt_q >= CNT_LAST) begin
        state_d = STALE;
        list_d  = '0;
        count_d = '0;
        prev_d  = '0;
        cnt_d   = CNT_SAT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Output next-state, computed from the list as it will be after this edge
  // so that keycode, key_event and held_frames all move together.
  always_comb begin
    newestIdx = list_d[2'(count_d - 3'd1)];
    keycode_d = (count_d == 3'd0) ? 8'h00 : idxToCode(newestIdx);
    event_d   = (keycode_d != keycode_q);

    if (keycode_d == 8'h00) begin
      held_d = '0;
    end else if (keycode_d != keycode_q) begin
      held_d = '0;
    end else if (held_q == {HOLD_W{1'b1}}) begin
      held_d = held_q;
    end else begin
      held_d = held_q + HOLD_W'(1);
    end
  end

  // All state registers, with synchronous reset back to an empty LIVE state.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= LIVE;
      list_q    <= '0;
      count_q   <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      keycode_q <= 8'h00;
      event_q   <= 1'b0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      count_q   <= count_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      keycode_q <= keycode_d;
      event_q   <= event_d;
      held_q    <= held_d;
    end
  end

  assign keycode     = keycode_q;
  assign key_event   = event_q;
  assign held_frames = held_q;
  assign stale       = (state_q == STALE);

endmodule
